// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches execute-stage outputs, runs one req/ack
// data-memory transaction per LD/ST/LDR and stalls upstream until it completes.
`timescale 1ns/1ps

`ifndef INST_NOP
`define INST_NOP 32'h8000_0000
`endif
`ifndef INST_BNE_EXCEPT
`define INST_BNE_EXCEPT 32'h47FF_FFFF
`endif

module mem_stage #(
    parameter int TIMEOUT   = 16,
    parameter int TIMEOUT_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic [31:0] ir,
    input  logic [31:0] y,
    input  logic [31:0] d,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_fault,
    output logic [31:0] pc_next,
    output logic [31:0] ir_next,
    output logic [31:0] y_next
);

    localparam logic [5:0] OP_LD  = 6'b011000;
    localparam logic [5:0] OP_ST  = 6'b011001;
    localparam logic [5:0] OP_LDR = 6'b011111;
    localparam logic [TIMEOUT_W-1:0] COUNT_LAST = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] COUNT_ONE  = TIMEOUT_W'(1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t               state_reg, state_next;
    logic [TIMEOUT_W-1:0] count_reg, count_next;
    logic [31:0]          pc_mem_reg, ir_mem_reg, y_mem_reg, d_mem_reg;

    logic [5:0] opcode;
    logic       is_st, mem_op, misaligned, complete;

    assign opcode     = ir_mem_reg[31:26];
    assign is_st      = (opcode == OP_ST);
    assign mem_op     = (opcode == OP_LD) || is_st || (opcode == OP_LDR);
    assign misaligned = mem_op && (y_mem_reg[1:0] != 2'b00);

    // Address and data come straight from the frozen stage regs, so they stay
    // stable for the whole transaction without separate holding registers.
    assign dmem_we    = is_st;
    assign dmem_addr  = {y_mem_reg[31:2], 2'b00};
    assign dmem_wdata = d_mem_reg;
    assign pc_next    = pc_mem_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            pc_mem_reg <= '0;
            ir_mem_reg <= `INST_NOP;
            y_mem_reg  <= '0;
            d_mem_reg  <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (!stall) begin
                pc_mem_reg <= pc;
                ir_mem_reg <= ir;
                y_mem_reg  <= y;
                d_mem_reg  <= d;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        dmem_req   = 1'b0;
        stall      = 1'b0;
        mem_fault  = 1'b0;
        complete   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (misaligned) begin
                    mem_fault = 1'b1;
                end else if (mem_op) begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        complete = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        state_next = WAIT;
                        count_next = COUNT_ONE;
                    end
                end
            end
            WAIT: begin
                dmem_req = 1'b1;
                // An ack arriving on the last allowed cycle still completes.
                if (dmem_ack) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                    count_next = '0;
                end else if (count_reg == COUNT_LAST) begin
                    dmem_req   = 1'b0;
                    mem_fault  = 1'b1;
                    state_next = IDLE;
                    count_next = '0;
                end else begin
                    stall      = 1'b1;
                    count_next = count_reg + COUNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase

        ir_next = ir_mem_reg;
        if (mem_fault) begin
            ir_next = `INST_BNE_EXCEPT;
        end else if (stall) begin
            ir_next = `INST_NOP;
        end
        y_next = (complete && !is_st) ? dmem_rdata : y_mem_reg;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: each op is expanded into its expected per-cycle outputs
// from its ack latency; directed sequences plus a long random stream.
`timescale 1ns/1ps

`ifndef INST_NOP
`define INST_NOP 32'h8000_0000
`endif
`ifndef INST_BNE_EXCEPT
`define INST_BNE_EXCEPT 32'h47FF_FFFF
`endif

module tb_mem_stage;
    localparam int TIMEOUT = 16;
    localparam logic [5:0] OP_LD  = 6'b011000;
    localparam logic [5:0] OP_ST  = 6'b011001;
    localparam logic [5:0] OP_LDR = 6'b011111;
    localparam logic [5:0] OP_ADD = 6'b000001;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, ir, y, d;
    logic        stall, dmem_req, dmem_we, dmem_ack, mem_fault;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] pc_next, ir_next, y_next;

    mem_stage #(.TIMEOUT(TIMEOUT), .TIMEOUT_W(5)) dut (
        .clk(clk), .rst(rst), .pc(pc), .ir(ir), .y(y), .d(d),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_fault(mem_fault),
        .pc_next(pc_next), .ir_next(ir_next), .y_next(y_next)
    );

    always #5 clk = ~clk;

    // lat = cycle of the request on which ack is given; beyond TIMEOUT means never
    typedef struct {
        logic [31:0] pc, ir, y, d, rdata;
        int          lat;
    } op_t;

    op_t         seq[$];
    op_t         bubble;
    int          tests = 0;
    int          fails = 0;
    int          n_stall, n_req, n_fault;
    logic [31:0] last_y;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic op_t mk(input logic [5:0] opc, input logic [31:0] ya,
                               input logic [31:0] da, input int lat, input logic [31:0] rd);
        op_t o;
        logic [31:0] r;
        r       = $urandom;
        o.pc    = $urandom;
        o.ir    = {opc, r[25:0]};
        o.y     = ya;
        o.d     = da;
        o.rdata = rd;
        o.lat   = lat;
        return o;
    endfunction

    function automatic logic is_mem(input logic [31:0] inst);
        return inst[31:26] == OP_LD || inst[31:26] == OP_ST || inst[31:26] == OP_LDR;
    endfunction

    // One clock cycle: drive upstream/memory inputs, then check every output.
    task automatic cycle(input op_t cur, input op_t nxt, input logic ack, input logic [31:0] rd,
                         input logic e_req, input logic e_stall, input logic e_fault,
                         input logic [31:0] e_ir, input logic [31:0] e_y);
        @(negedge clk);
        pc = nxt.pc; ir = nxt.ir; y = nxt.y; d = nxt.d;
        dmem_ack = ack; dmem_rdata = rd;
        #1;
        chk("stall", {31'b0, stall}, {31'b0, e_stall});
        chk("dmem_req", {31'b0, dmem_req}, {31'b0, e_req});
        chk("mem_fault", {31'b0, mem_fault}, {31'b0, e_fault});
        chk("pc_next", pc_next, cur.pc);
        chk("ir_next", ir_next, e_ir);
        chk("y_next", y_next, e_y);
        if (e_req) begin
            chk("dmem_we", {31'b0, dmem_we}, {31'b0, (cur.ir[31:26] == OP_ST)});
            chk("dmem_addr", dmem_addr, {cur.y[31:2], 2'b00});
            chk("dmem_wdata", dmem_wdata, cur.d);
        end
        n_stall += int'(stall);
        n_req   += int'(dmem_req);
        n_fault += int'(mem_fault);
    endtask

    // Expand one op into its expected cycles while nxt waits upstream.
    task automatic run_op(input op_t cur, input op_t nxt);
        logic mis;
        logic ld;
        int   n;
        mis = is_mem(cur.ir) && (cur.y[1:0] != 2'b00);
        ld  = is_mem(cur.ir) && (cur.ir[31:26] != OP_ST);
        if (!is_mem(cur.ir) || mis) begin
            cycle(cur, nxt, 1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0, mis,
                  mis ? `INST_BNE_EXCEPT : cur.ir, cur.y);
        end else begin
            n = (cur.lat < TIMEOUT) ? cur.lat : TIMEOUT;
            for (int c = 1; c < n; c++)
                cycle(cur, nxt, 1'b0, $urandom, 1'b1, 1'b1, 1'b0, `INST_NOP, cur.y);
            if (cur.lat <= TIMEOUT) begin
                cycle(cur, nxt, 1'b1, cur.rdata, 1'b1, 1'b0, 1'b0, cur.ir,
                      ld ? cur.rdata : cur.y);
                last_y = y_next;
            end else begin
                cycle(cur, nxt, 1'b0, $urandom, 1'b0, 1'b0, 1'b1, `INST_BNE_EXCEPT, cur.y);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dmem_ack = 1'b0; dmem_rdata = $urandom;
        pc = $urandom; ir = {OP_LD, 26'h0}; y = 32'h100; d = $urandom;
        @(negedge clk); #1;
        chk("rst stall", {31'b0, stall}, 32'd0);
        chk("rst dmem_req", {31'b0, dmem_req}, 32'd0);
        chk("rst mem_fault", {31'b0, mem_fault}, 32'd0);
        chk("rst ir_next", ir_next, `INST_NOP);
        chk("rst y_next", y_next, 32'd0);
        chk("rst pc_next", pc_next, 32'd0);
        pc = 32'd0; ir = `INST_NOP; y = 32'd0; d = 32'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_seq();
        do_reset();
        n_stall = 0; n_req = 0; n_fault = 0; last_y = 32'd0;
        run_op(bubble, seq[0]);
        for (int i = 0; i < seq.size(); i++)
            run_op(seq[i], (i + 1 < seq.size()) ? seq[i + 1] : bubble);
    endtask

    function automatic op_t rand_op();
        logic [5:0]  opc;
        logic [31:0] ya;
        int          sel, u, lat;
        sel = $urandom_range(0, 3);
        if (sel == 0) opc = OP_LD;
        else if (sel == 1) opc = OP_ST;
        else if (sel == 2) opc = OP_LDR;
        else begin
            do opc = 6'($urandom_range(0, 63)); while (is_mem({opc, 26'h0}));
        end
        ya = $urandom;
        if ($urandom_range(0, 4) != 0) ya[1:0] = 2'b00;
        u   = $urandom_range(0, 19);
        lat = (u < 14) ? $urandom_range(1, 4) : $urandom_range(14, 19);
        return mk(opc, ya, $urandom, lat, $urandom);
    endfunction

    initial begin
        bubble = '{pc: 32'd0, ir: `INST_NOP, y: 32'd0, d: 32'd0, rdata: 32'd0, lat: 0};
        rst = 1'b1;

        // ADD then LD with same-cycle ack
        seq = {};
        seq.push_back(mk(OP_ADD, 32'h55, 32'h0, 1, 32'h0));
        seq.push_back(mk(OP_LD, 32'h100, 32'h0, 1, 32'hCAFEF00D));
        run_seq();
        chk("ld same-cycle stalls", n_stall, 0);
        chk("ld same-cycle data", last_y, 32'hCAFEF00D);

        // ST acked on its 4th request cycle
        seq = {};
        seq.push_back(mk(OP_ST, 32'h40, 32'h12345678, 4, 32'h0));
        run_seq();
        chk("st stall count", n_stall, 3);
        chk("st req count", n_req, 4);

        // misaligned LD
        seq = {};
        seq.push_back(mk(OP_LD, 32'h102, 32'h0, 1, 32'h0));
        run_seq();
        chk("misaligned req count", n_req, 0);
        chk("misaligned fault count", n_fault, 1);

        // LD never acked
        seq = {};
        seq.push_back(mk(OP_LD, 32'h200, 32'h0, 100, 32'h0));
        run_seq();
        chk("timeout stall count", n_stall, 15);
        chk("timeout fault count", n_fault, 1);
        chk("timeout req count", n_req, 15);

        // LDR, LD, ST back-to-back
        seq = {};
        seq.push_back(mk(OP_LDR, 32'h300, 32'h0, 1, 32'h11111111));
        seq.push_back(mk(OP_LD, 32'h304, 32'h0, 1, 32'h22222222));
        seq.push_back(mk(OP_ST, 32'h308, 32'hABCD0123, 1, 32'h0));
        run_seq();
        chk("b2b req count", n_req, 3);
        chk("b2b stall count", n_stall, 0);

        // async reset in the middle of a stalled ST
        seq = {};
        seq.push_back(mk(OP_ST, 32'h40, 32'h12345678, 100, 32'h0));
        do_reset();
        run_op(bubble, seq[0]);
        for (int c = 0; c < 3; c++)
            cycle(seq[0], bubble, 1'b0, $urandom, 1'b1, 1'b1, 1'b0, `INST_NOP, seq[0].y);
        #1 rst = 1'b1;
        #1;
        chk("rst mid-wait req", {31'b0, dmem_req}, 32'd0);
        chk("rst mid-wait stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("post-rst ir_next", ir_next, `INST_NOP);
        chk("post-rst req", {31'b0, dmem_req}, 32'd0);

        // random stream
        seq = {};
        for (int i = 0; i < 300; i++) seq.push_back(rand_op());
        run_seq();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
